fifo_sync_prog: RTL
===================

Name: fifo_sync_prog

Overview:
Single-clock FIFO buffer that generalises the team's dual-clock FIFO for same-domain buffering. Supports arbitrary (non-power-of-two) depth and an occupancy count output. Provides programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Used between same-clock producer/consumer stages and as the buffer under test in BIST.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 10, number of storage entries; any value >= 2
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_THRESH, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_THRESH; legal 1..DEPTH
AE_THRESH, 2, ALMOST_EMPTY asserts when COUNT <= AE_THRESH; legal 0..DEPTH-1
(derived) AW = $clog2(DEPTH), CW = $clog2(DEPTH+1); an illegal parameter set is an elaboration error

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  reset; asynchronous assert, active-low (0 = reset)
CLR  in  1  synchronous flush, active-high
W_EN  in  1  write request
W_DATA  in  DATA_WIDTH  write data
R_EN  in  1  read request (FWFT=1: pop/acknowledge of head word)
R_DATA  out  DATA_WIDTH  read data
R_VALID  out  1  R_DATA holds valid data
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
ALMOST_FULL  out  1  COUNT >= AF_THRESH
ALMOST_EMPTY  out  1  COUNT <= AE_THRESH
COUNT  out  CW  current occupancy, 0..DEPTH
OVERFLOW  out  1  sticky: write attempted while FULL
UNDERFLOW  out  1  sticky: read attempted while EMPTY

Behaviour:
- Reset (RST=0, asynchronous): write pointer, read pointer, COUNT = 0; R_DATA = 0; R_VALID = 0; OVERFLOW = UNDERFLOW = 0. Flags follow COUNT: EMPTY = 1, ALMOST_EMPTY = 1, FULL = 0, ALMOST_FULL = 0. The storage array is not reset.
- CLR=1 at an edge: same state as reset except R_DATA is held. CLR has priority over W_EN/R_EN in that cycle; no write or read is accepted, and no error flag is set.
- Write accept: W_EN & ~FULL. The word is stored at the write pointer and the pointer advances. W_EN & FULL drops the word, leaves state unchanged, and sets OVERFLOW.
- Read accept: R_EN & ~EMPTY. The read pointer advances. R_EN & EMPTY changes nothing except setting UNDERFLOW.
- Acceptance is decided on the registered FULL/EMPTY values. When FULL, a simultaneous write is rejected even if a read is accepted. When EMPTY, a simultaneous read is rejected even if a write is accepted.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0 on advance. Binary compare only; no power-of-two assumption.
- COUNT update per edge: +1 write only, -1 read only, unchanged when both or neither are accepted.
- All flags decode combinationally from the registered COUNT. They change in the cycle after the accepting edge and add no latency beyond that.
- FWFT=0: on a read-accept edge, R_DATA <= mem[rd_ptr] and R_VALID <= 1. On a non-accept edge, R_VALID <= 0 and R_DATA holds. Read latency is 1 cycle.
- FWFT=1: R_DATA = mem[rd_ptr] (asynchronous read) and R_VALID = ~EMPTY. The first written word is visible on R_DATA in the cycle after its write edge. R_EN while R_VALID consumes it.
- OVERFLOW/UNDERFLOW stay set until RST or CLR.
- Write-after-read on the same address in one cycle cannot occur, because the write pointer never equals the read pointer while 0 < COUNT < DEPTH.

Test Plan:
1. DEPTH=10: 10 writes 0x01..0x0A with no reads -> COUNT=10, FULL=1, ALMOST_FULL=1 from COUNT=8. An 11th write 0xFF -> OVERFLOW=1, COUNT stays 10; 10 subsequent reads return 0x01..0x0A in order.
2. Wrap-around: 7 writes, 7 reads, then 6 writes 0x10..0x15 -> pointers cross 9->0; the reads return 0x10..0x15 and EMPTY=1 after the last read.
3. FIFO at COUNT=4, W_EN=R_EN=1 for 5 cycles -> COUNT stays 4 throughout. At FULL, W_EN=R_EN=1 -> the read is accepted, the write is dropped, OVERFLOW=1, COUNT=9.
4. Empty FIFO, R_EN=1 -> UNDERFLOW=1, R_VALID=0, COUNT=0. Then CLR=1 for 1 cycle -> UNDERFLOW=0.
5. FWFT=1: write 0xA5 at edge N -> R_VALID=1 and R_DATA=0xA5 in cycle N+1 with no R_EN. R_EN=1 -> EMPTY=1 next cycle. FWFT=0, same stimulus -> R_DATA=0xA5 and R_VALID=1 only in the cycle after the R_EN edge.
6. COUNT=6, then RST driven low mid-cycle with no clock edge -> COUNT=0, EMPTY=1, R_VALID=0 immediately. After release, a write of 0x3C is read back as 0x3C.

Source files
------------

// File: rtl/fifo_sync_prog_if.sv
// Handshake bundle for fifo_sync_prog: producer/consumer side is master, FIFO is slave.
// DATA_WIDTH and DEPTH must match the FIFO instance the bundle is bound to.
interface fifo_sync_prog_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10,
    parameter int CW         = $clog2(DEPTH + 1)
);
    logic                  CLR;
    logic                  W_EN;
    logic [DATA_WIDTH-1:0] W_DATA;
    logic                  R_EN;
    logic [DATA_WIDTH-1:0] R_DATA;
    logic                  R_VALID;
    logic                  FULL;
    logic                  EMPTY;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;
    logic [CW-1:0]         COUNT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output CLR, W_EN, W_DATA, R_EN,
        input  R_DATA, R_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  CLR, W_EN, W_DATA, R_EN,
        output R_DATA, R_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable almost flags,
// sticky error flags, synchronous flush and selectable first-word-fall-through read.
module fifo_sync_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic            CLK,
    input  logic            RST,
    fifo_sync_prog_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1 || (FWFT != 0 && FWFT != 1)) begin : g_bad_param
        $error("fifo_sync_prog: illegal parameter set");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, unf_q;
    logic                  full, empty, wr_acc, rd_acc;

    // Acceptance uses the registered occupancy, so a full FIFO rejects a write even
    // when a read leaves room in the same cycle.
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.W_EN & ~full  & ~bus.CLR;
    assign rd_acc = bus.R_EN & ~empty & ~bus.CLR;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (bus.CLR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (bus.W_EN && full)  ovf_q <= 1'b1;
            if (bus.R_EN && empty) unf_q <= 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.W_DATA;
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.R_DATA  = mem_q[rd_ptr_q];
        assign bus.R_VALID = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (rd_acc) begin
                rdata_q  <= mem_q[rd_ptr_q];
                rvalid_q <= 1'b1;
            end else begin
                rvalid_q <= 1'b0;
            end
        end
        assign bus.R_DATA  = rdata_q;
        assign bus.R_VALID = rvalid_q;
    end

    assign bus.FULL         = full;
    assign bus.EMPTY        = empty;
    assign bus.ALMOST_FULL  = (count_q >= AF_C);
    assign bus.ALMOST_EMPTY = (count_q <= AE_C);
    assign bus.COUNT        = count_q;
    assign bus.OVERFLOW     = ovf_q;
    assign bus.UNDERFLOW    = unf_q;
endmodule
